// File: rtl/bs_sequencer_if.sv
// Instruction handshake and datapath control bundle between an instruction source
// and the bit-serial ALU sequencer.
interface bs_sequencer_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned CNT_W   = $clog2(DATA_W)
);
  logic [3:0]         opcode;
  logic [11:0]        instr;
  logic               inst_done;
  logic               btn_edge;
  logic               run_mode;

  logic [RADDR_W-1:0] rs1;
  logic [RADDR_W-1:0] rs2;
  logic [RADDR_W-1:0] rd;
  logic               reg_shift_en;
  logic               imm_shift_en;
  logic               acc_shift_en;
  logic               reg_write_en;
  logic [1:0]         alu_op;
  logic               b_invert;
  logic               carry_preset;
  logic               carry_preset_val;
  logic               carry_en;
  logic [CNT_W-1:0]   bit_idx;
  logic               busy;
  logic               done;
  logic               illegal;

  modport master (
    output opcode, instr, inst_done, btn_edge, run_mode,
    input  rs1, rs2, rd, reg_shift_en, imm_shift_en, acc_shift_en, reg_write_en,
    input  alu_op, b_invert, carry_preset, carry_preset_val, carry_en, bit_idx,
    input  busy, done, illegal
  );

  modport slave (
    input  opcode, instr, inst_done, btn_edge, run_mode,
    output rs1, rs2, rd, reg_shift_en, imm_shift_en, acc_shift_en, reg_write_en,
    output alu_op, b_invert, carry_preset, carry_preset_val, carry_en, bit_idx,
    output busy, done, illegal
  );
endinterface

// File: rtl/bs_sequencer.sv
// Control FSM for a bit-serial ALU: latches one instruction, then strobes the serial
// datapath through DATA_W execute cycles and DATA_W writeback cycles.
module bs_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RADDR_W = 3,
  parameter int unsigned CNT_W   = $clog2(DATA_W)
) (
  input logic           clk,
  input logic           rstn,
  bs_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StExecute,
    StWriteback,
    StDone
  } state_e;

  localparam logic [2:0] FnAdd = 3'b000;
  localparam logic [2:0] FnSub = 3'b001;
  localparam logic [2:0] FnOr  = 3'b100;
  localparam logic [2:0] FnAnd = 3'b101;
  localparam logic [2:0] FnXor = 3'b110;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [3:0]         opcode_q, opcode_d;
  logic [11:0]        instr_q, instr_d;
  logic [CNT_W-1:0]   bit_idx_q, bit_idx_d;

  logic               start;
  logic               is_imm;
  logic               is_sub;
  logic               legal;
  logic               last_bit;
  logic [2:0]         fn;
  logic [1:0]         alu_sel;
  logic [RADDR_W-1:0] rd_addr;

  assign start    = bus.inst_done & (bus.run_mode | bus.btn_edge);
  assign fn       = opcode_q[2:0];
  assign is_imm   = opcode_q[3];
  assign is_sub   = (fn == FnSub);
  assign last_bit = (bit_idx_q == LastIdx);
  // Immediate form writes back to its single source register.
  assign rd_addr  = RADDR_W'(is_imm ? instr_q[2:0] : instr_q[11:9]);

  always_comb begin
    legal   = 1'b0;
    alu_sel = 2'b00;
    unique case (fn)
      FnAdd, FnSub: legal = 1'b1;
      FnOr: begin
        legal   = 1'b1;
        alu_sel = 2'b11;
      end
      FnAnd: begin
        legal   = 1'b1;
        alu_sel = 2'b10;
      end
      FnXor: begin
        legal   = 1'b1;
        alu_sel = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    instr_d   = instr_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StDecode;
          opcode_d = bus.opcode;
          instr_d  = bus.instr;
        end
      end
      StDecode: state_d = legal ? StExecute : StIdle;
      StExecute: begin
        if (last_bit) begin
          bit_idx_d = '0;
          state_d   = StWriteback;
        end else begin
          bit_idx_d = bit_idx_q + CNT_W'(1);
        end
      end
      StWriteback: begin
        if (last_bit) begin
          bit_idx_d = '0;
          state_d   = StDone;
        end else begin
          bit_idx_d = bit_idx_q + CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      opcode_q  <= '0;
      instr_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      instr_q   <= instr_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Outputs depend only on registered state and latched fields, never on live inputs.
  always_comb begin
    bus.rs1              = RADDR_W'(is_imm ? instr_q[2:0] : instr_q[8:6]);
    bus.rs2              = is_imm ? '0 : RADDR_W'(instr_q[5:3]);
    bus.rd               = rd_addr;
    bus.reg_shift_en     = 1'b0;
    bus.imm_shift_en     = 1'b0;
    bus.acc_shift_en     = 1'b0;
    bus.reg_write_en     = 1'b0;
    bus.alu_op           = 2'b00;
    bus.b_invert         = 1'b0;
    bus.carry_preset     = 1'b0;
    bus.carry_preset_val = 1'b0;
    bus.carry_en         = 1'b0;
    bus.bit_idx          = '0;
    bus.busy             = (state_q != StIdle);
    bus.done             = 1'b0;
    bus.illegal          = 1'b0;
    unique case (state_q)
      StIdle: ;
      StDecode: begin
        bus.carry_preset     = legal;
        bus.carry_preset_val = legal & is_sub;
        bus.illegal          = ~legal;
      end
      StExecute: begin
        bus.reg_shift_en = 1'b1;
        bus.imm_shift_en = is_imm;
        bus.acc_shift_en = 1'b1;
        bus.carry_en     = 1'b1;
        bus.alu_op       = alu_sel;
        bus.b_invert     = is_sub;
        bus.bit_idx      = bit_idx_q;
      end
      StWriteback: begin
        bus.acc_shift_en = 1'b1;
        // Writes to r0 are discarded but the cycles still elapse.
        bus.reg_write_en = (rd_addr != '0);
        bus.bit_idx      = bit_idx_q;
      end
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bs_sequencer.sv
// Scoreboard bench for bs_sequencer: an 8-bit instance in step mode and a 16-bit
// instance in run mode, sharing clock and reset.
module tb_bs_sequencer;

  localparam int unsigned W8  = 8;
  localparam int unsigned W16 = 16;

  localparam int unsigned NOPS = 6;
  localparam logic [3:0]  OPS [NOPS] = '{4'b0000, 4'b1001, 4'b0100, 4'b1101, 4'b0110, 4'b1110};
  localparam logic [11:0] INS [NOPS] = '{
    {3'd2, 3'd3, 3'd4, 3'd0},
    {8'h05, 1'b0, 3'd3},
    {3'd7, 3'd1, 3'd6, 3'd5},
    {8'hA3, 1'b0, 3'd6},
    {3'd4, 3'd5, 3'd2, 3'd1},
    {8'h3C, 1'b0, 3'd0}
  };
  localparam logic [3:0]  ILL [3] = '{4'b0011, 4'b1111, 4'b1010};

  typedef struct {
    int         due;
    bit         ill;
    bit         imm;
    int         exec_n;
    int         wb_n;
    int         wr_n;
    int         imm_n;
    int         binv_n;
    bit         cpv;
    logic [1:0] alu;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_t q8[$];
  int   q16[$];

  int         m_exec, m_wb, m_wr, m_imm, m_binv, m_pre, m_bad;
  bit         m_cpv;
  logic [1:0] m_alu;
  logic [2:0] m_rd, m_rs1, m_rs2;
  int         m16_max = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bs_sequencer_if #(.DATA_W(W8))  b8 ();
  bs_sequencer_if #(.DATA_W(W16)) b16 ();

  bs_sequencer #(.DATA_W(W8)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b8)
  );

  bs_sequencer #(.DATA_W(W16)) u_dut16 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (b16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs8();
    return 32'({b8.rs1, b8.rs2, b8.rd, b8.reg_shift_en, b8.imm_shift_en, b8.acc_shift_en,
                b8.reg_write_en, b8.alu_op, b8.b_invert, b8.carry_preset, b8.carry_preset_val,
                b8.carry_en, b8.bit_idx, b8.busy, b8.done, b8.illegal});
  endfunction

  function automatic logic [31:0] outs16();
    return 32'({b16.rs1, b16.rs2, b16.rd, b16.reg_shift_en, b16.imm_shift_en, b16.acc_shift_en,
                b16.reg_write_en, b16.alu_op, b16.b_invert, b16.carry_preset,
                b16.carry_preset_val, b16.carry_en, b16.bit_idx, b16.busy, b16.done,
                b16.illegal});
  endfunction

  task automatic clr_mon();
    m_exec = 0; m_wb = 0; m_wr = 0; m_imm = 0; m_binv = 0; m_pre = 0; m_bad = 0;
    m_cpv = 1'b0; m_alu = 2'b00; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
  endtask

  // Reference model of one 8-bit operation started in cycle t.
  task automatic push_exp(input logic [3:0] op, input logic [11:0] ins, input int t);
    exp_t       e;
    logic [2:0] f;
    f        = op[2:0];
    e.imm    = op[3];
    e.ill    = !(f inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110});
    e.due    = e.ill ? t + 1 : t + 2 + 2 * W8;
    e.exec_n = e.ill ? 0 : W8;
    e.wb_n   = e.ill ? 0 : W8;
    e.rd     = e.imm ? ins[2:0] : ins[11:9];
    e.rs1    = e.imm ? ins[2:0] : ins[8:6];
    e.rs2    = ins[5:3];
    e.wr_n   = (e.ill || e.rd == 3'd0) ? 0 : W8;
    e.imm_n  = (e.imm && !e.ill) ? W8 : 0;
    e.binv_n = (f == 3'b001) ? W8 : 0;
    e.cpv    = (f == 3'b001);
    case (f)
      3'b100:  e.alu = 2'b11;
      3'b101:  e.alu = 2'b10;
      3'b110:  e.alu = 2'b01;
      default: e.alu = 2'b00;
    endcase
    q8.push_back(e);
  endtask

  task automatic score8();
    exp_t e;
    check_eq("sb8_has_entry", 32'(q8.size() != 0), 1);
    if (q8.size() != 0) begin
      e = q8.pop_front();
      check_eq("op_end_cycle", cyc, e.due);
      check_eq("illegal_flag", 32'(b8.illegal), 32'(e.ill));
      check_eq("exec_cycles", m_exec, e.exec_n);
      check_eq("wb_cycles", m_wb, e.wb_n);
      check_eq("reg_write_cycles", m_wr, e.wr_n);
      check_eq("imm_shift_cycles", m_imm, e.imm_n);
      check_eq("b_invert_cycles", m_binv, e.binv_n);
      check_eq("carry_preset_cnt", m_pre, e.ill ? 0 : 1);
      check_eq("carry_preset_val", 32'(m_cpv), 32'(e.cpv));
      check_eq("alu_op", 32'(m_alu), 32'(e.alu));
      check_eq("rd", 32'(m_rd), 32'(e.rd));
      check_eq("rs1", 32'(m_rs1), 32'(e.rs1));
      if (!e.imm) check_eq("rs2", 32'(m_rs2), 32'(e.rs2));
      check_eq("strobe_idx_errors", m_bad, 0);
    end
    clr_mon();
  endtask

  // Per-cycle observer for the 8-bit instance.
  always @(negedge clk) begin
    if (!rstn) begin
      clr_mon();
    end else begin
      if (b8.carry_preset) begin
        m_pre++;
        m_cpv = b8.carry_preset_val;
      end
      if (b8.carry_en) begin
        if (int'(b8.bit_idx) != m_exec || !b8.reg_shift_en || !b8.acc_shift_en ||
            b8.reg_write_en) m_bad++;
        m_exec++;
        m_imm  += int'(b8.imm_shift_en);
        m_binv += int'(b8.b_invert);
        m_alu  = b8.alu_op;
      end else if (b8.acc_shift_en) begin
        if (int'(b8.bit_idx) != m_wb || b8.reg_shift_en || b8.imm_shift_en || b8.b_invert)
          m_bad++;
        m_wb++;
        m_wr += int'(b8.reg_write_en);
      end else if (b8.bit_idx != 0 || b8.reg_shift_en || b8.imm_shift_en ||
                   b8.reg_write_en || b8.b_invert) begin
        m_bad++;
      end
      if (b8.busy) begin
        m_rd  = b8.rd;
        m_rs1 = b8.rs1;
        m_rs2 = b8.rs2;
      end
      if (b8.done || b8.illegal) score8();
    end
  end

  // Observer for the 16-bit run-mode instance.
  always @(negedge clk) begin
    if (!rstn) begin
      m16_max = 0;
    end else begin
      if (int'(b16.bit_idx) > m16_max) m16_max = int'(b16.bit_idx);
      if (b16.done) begin
        check_eq("sb16_has_entry", 32'(q16.size() != 0), 1);
        if (q16.size() != 0) begin
          check_eq("run_done_cycle", cyc, q16.pop_front());
          check_eq("run_bit_idx_max", m16_max, W16 - 1);
        end
        m16_max = 0;
      end
    end
  end

  task automatic step_op(input logic [3:0] op, input logic [11:0] ins);
    @(negedge clk);
    b8.opcode    = op;
    b8.instr     = ins;
    b8.inst_done = 1'b1;
    b8.btn_edge  = 1'b1;
    push_exp(op, ins, cyc);
    @(negedge clk);
    // Scramble the inputs to prove the operation runs from latched fields.
    b8.inst_done = 1'b0;
    b8.btn_edge  = 1'b0;
    b8.opcode    = 4'($urandom);
    b8.instr     = 12'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (b8.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_within_budget", 32'(b8.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int t0;
    rstn = 1'b0;
    b8.opcode = '0;  b8.instr = '0;  b8.inst_done = 1'b0;  b8.btn_edge = 1'b0;
    b8.run_mode = 1'b0;
    b16.opcode = '0; b16.instr = '0; b16.inst_done = 1'b0; b16.btn_edge = 1'b0;
    b16.run_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst8_outs", outs8(), 0);
    check_eq("rst16_outs", outs16(), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst8_outs", outs8(), 0);

    // Step mode needs btn_edge and inst_done together.
    b8.inst_done = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("no_start_without_btn", 32'(b8.busy), 0);
    b8.inst_done = 1'b0;
    b8.btn_edge  = 1'b1;
    @(negedge clk);
    b8.btn_edge  = 1'b0;
    @(negedge clk);
    check_eq("no_start_without_inst", 32'(b8.busy), 0);

    for (int i = 0; i < NOPS; i++) begin
      step_op(OPS[i], INS[i]);
      wait_idle(3 * W8 + 10);
    end

    for (int i = 0; i < 3; i++) begin
      step_op(ILL[i], 12'($urandom));
      @(negedge clk);
      check_eq("illegal_busy_low_t2", 32'(b8.busy), 0);
    end

    // Further start requests while busy must be dropped, not queued.
    step_op(4'b0000, {3'd1, 3'd2, 3'd3, 3'd0});
    @(negedge clk);
    b8.inst_done = 1'b1;
    b8.btn_edge  = 1'b1;
    @(negedge clk);
    b8.btn_edge  = 1'b0;
    @(negedge clk);
    b8.btn_edge  = 1'b1;
    @(negedge clk);
    b8.btn_edge  = 1'b0;
    b8.inst_done = 1'b0;
    wait_idle(3 * W8 + 10);
    repeat (4) @(negedge clk);
    check_eq("no_queued_start", 32'(b8.busy), 0);

    step_op(4'b0000, {3'd0, 3'd6, 3'd7, 3'd0});
    wait_idle(3 * W8 + 10);

    // Reset in the middle of writeback.
    step_op(4'b0000, {3'd5, 3'd1, 3'd2, 3'd0});
    n = 0;
    while (!(b8.acc_shift_en && !b8.carry_en && b8.bit_idx == 3'd4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_wb_idx4", 32'(n < 40), 1);
    rstn = 1'b0;
    #1;
    check_eq("midop_rst_outs", outs8(), 0);
    q8.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_eq("post_midop_outs", outs8(), 0);
    step_op(4'b0100, {3'd3, 3'd4, 3'd5, 3'd0});
    wait_idle(3 * W8 + 10);

    // Run mode on the 16-bit instance: back-to-back operations every 2*W+3 cycles.
    @(negedge clk);
    b16.opcode    = 4'b0000;
    b16.instr     = {3'd1, 3'd2, 3'd3, 3'd0};
    b16.run_mode  = 1'b1;
    b16.inst_done = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) q16.push_back(t0 + 2 + 2 * W16 + k * (2 * W16 + 3));
    repeat (2 * (2 * W16 + 3) + 2 + 2 * W16) @(negedge clk);
    b16.inst_done = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("run16_idle_after", 32'(b16.busy), 0);

    check_eq("sb8_drained", q8.size(), 0);
    check_eq("sb16_drained", q16.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bs_sequencer.md
BS_SEQUENCER -- requirements
Module: bs_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the serial operand width in bits (legal values 2..32).
REQ-002 The module SHALL have parameter RADDR_W, default 3, giving the register-address width.
REQ-003 The module SHALL have parameter CNT_W, default $clog2(DATA_W), giving the bit-index width.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 opcode  in  4  instruction opcode; bit3=1 means immediate form.
REQ-007 instr  in  12  instruction bits 15:4.
REQ-008 inst_done  in  1  a full instruction is present on opcode/instr.
REQ-009 btn_edge  in  1  one-cycle step pulse.
REQ-010 run_mode  in  1  1 = start without btn_edge; 0 = single-step.
REQ-011 rs1, rs2, rd  out  RADDR_W each  latched register addresses.
REQ-012 reg_shift_en, imm_shift_en, acc_shift_en, reg_write_en  out  1 each  datapath strobes.
REQ-013 alu_op  out  2  00 add, 01 xor, 10 and, 11 or.
REQ-014 b_invert  out  1  invert ALU B operand (subtract).
REQ-015 carry_preset, carry_preset_val, carry_en  out  1 each  carry flop load pulse, load value, carry update enable.
REQ-016 bit_idx  out  CNT_W  current serial bit index.
REQ-017 busy, done, illegal  out  1 each  status; done and illegal are one-cycle pulses.

Function
REQ-018 States SHALL be IDLE, DECODE, EXECUTE, WRITEBACK, DONE; all outputs decoded from registered state and latched fields only.
REQ-019 IDLE->DECODE SHALL occur when inst_done=1 and (run_mode=1 or btn_edge=1); otherwise remain in IDLE.
REQ-020 On IDLE->DECODE the block SHALL latch opcode and instr; later input changes SHALL not affect the operation in flight.
REQ-021 Field decode: rd=instr[11:9]; R-type (bit3=0): rs1=instr[8:6], rs2=instr[5:3], reg_shift_en drives both operands; I-type (bit3=1): rs1=instr[2:0], imm=instr[11:4] shifted via imm_shift_en, rd=rs1.
REQ-022 Legal opcode[2:0]: 000 ADD, 001 SUB, 100 OR, 101 AND, 110 XOR; others SHALL be illegal.
REQ-023 DECODE SHALL last one cycle; legal: assert carry_preset, carry_preset_val=1 for SUB else 0, then EXECUTE; illegal: pulse illegal, return to IDLE, assert no datapath strobe.
REQ-024 EXECUTE SHALL last exactly DATA_W cycles with reg_shift_en (R) or reg_shift_en+imm_shift_en (I), acc_shift_en, carry_en, alu_op per REQ-013, b_invert=1 only for SUB.
REQ-025 WRITEBACK SHALL last exactly DATA_W cycles with acc_shift_en=1 and reg_write_en=1, except reg_write_en SHALL stay 0 when rd=0 (discard; cycles still elapse).
REQ-026 bit_idx SHALL be 0 on entry to EXECUTE and WRITEBACK, increment each cycle, reach DATA_W-1 on the last cycle, and be 0 in all other states.
REQ-027 DONE SHALL last one cycle with done=1, then IDLE.
REQ-028 Latency: start qualified in cycle T -> DECODE T+1, EXECUTE T+2..T+1+DATA_W, WRITEBACK T+2+DATA_W..T+1+2*DATA_W, done at T+2+2*DATA_W.
REQ-029 busy SHALL be 1 in every state except IDLE; btn_edge/inst_done while busy SHALL be ignored (no queueing).
REQ-030 In run_mode with inst_done held high, a new start SHALL be accepted in the first IDLE cycle after DONE.

Reset
REQ-031 rstn=0 SHALL force IDLE immediately, regardless of state, including mid-EXECUTE/WRITEBACK.
REQ-032 During and after reset all outputs SHALL be 0 (alu_op=00, bit_idx=0, rs1/rs2/rd=0) until a new start.

Verification
REQ-033 DATA_W=8, step mode, ADD R-type rd=2: btn_edge with inst_done -> carry_preset_val=0, 8 EXECUTE cycles, 8 reg_write_en cycles, done at T+18.
REQ-034 SUB I-type imm=0x05 rs1=3 -> carry_preset_val=1, b_invert=1 and imm_shift_en=1 for 8 cycles, rd=3.
REQ-035 opcode 4'b0011 -> illegal pulse at T+1, no strobes, busy low at T+2.
REQ-036 btn_edge pulses during EXECUTE -> ignored, exactly one done; ADD with rd=0 -> reg_write_en never 1, done still at T+18.
REQ-037 rstn low at bit_idx=4 of WRITEBACK -> all outputs 0 immediately; next start runs a full sequence.
REQ-038 DATA_W=16, run_mode=1, inst_done high -> back-to-back operations, done every 35 cycles, bit_idx reaching 15.
